ads868x_scan_seq: RTL

- Parametrised successor to the single-channel ADS868x control path.
- Autonomously scans up to NUM_CH external analog-mux channels and drives the mux select/enable lines.
- Waits a programmable settle time per channel, then runs one SPI conversion frame through the existing byte-wide AXIS SPI master.
- Emits channel-tagged, scan-tagged samples on an AXI-Stream output, with optional PPS-aligned scan start and overflow detection.

---
 rtl/ads868x_scan_seq.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/ads868x_scan_seq.sv
// Multi-channel scan sequencer for the ADS868x: steps an external analog mux,
// waits a settle time, runs one SPI frame per channel and emits tagged samples.
module ads868x_scan_seq #(
  parameter int NUM_CH      = 8,
  parameter int CH_W        = 3,
  parameter int FRAME_BYTES = 4,
  parameter int ADC_BITS    = 16,
  parameter int SETTLE_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ctrl_enable,
  input  logic                     ctrl_pps_sync,
  input  logic [NUM_CH-1:0]        ctrl_ch_mask,
  input  logic [SETTLE_W-1:0]      ctrl_settle,
  input  logic [8*FRAME_BYTES-1:0] ctrl_cmd,
  input  logic                     stat_clr_overflow,
  input  logic                     pps,
  output logic [CH_W-1:0]          mux_sel,
  output logic                     mux_en,
  output logic [7:0]               spi_tx_tdata,
  output logic                     spi_tx_tvalid,
  input  logic                     spi_tx_tready,
  input  logic [7:0]               spi_rx_tdata,
  input  logic                     spi_rx_tvalid,
  output logic                     spi_rx_tready,
  output logic [31:0]              m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic                     stat_busy,
  output logic                     stat_overflow,
  output logic [15:0]              stat_scan_cnt
);

  localparam int         FRAME_W = 8 * FRAME_BYTES;
  localparam logic [2:0] FB      = 3'(FRAME_BYTES);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    SETTLE = 3'd2,
    XFER   = 3'd3,
    STORE  = 3'd4
  } state_t;

  state_t               state;
  logic                 pps_q;
  logic                 pps_rise;
  logic [NUM_CH-1:0]    mask_q;
  logic [CH_W-1:0]      ptr;
  logic [SETTLE_W-1:0]  settle_cnt;
  logic [2:0]           tx_cnt;
  logic [2:0]           tx_nxt;
  logic [2:0]           rx_cnt;
  logic [FRAME_W-1:0]   rx_frame;
  logic                 tx_valid_q;
  logic                 out_valid_q;
  logic [15:0]          scan_cnt;
  logic                 tx_hs;
  logic                 rx_take;
  logic [15:0]          sample;
  logic                 nxt_found;
  logic [CH_W-1:0]      nxt_ch;

  function automatic logic [CH_W-1:0] lowest_set(input logic [NUM_CH-1:0] m);
    logic [CH_W-1:0] idx;
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i]) idx = CH_W'(i);
    end
    return idx;
  endfunction

  // Byte k of the command word, counted from the MSB end.
  function automatic logic [7:0] cmd_byte(input logic [FRAME_W-1:0] cmd, input logic [2:0] k);
    logic [FRAME_W-1:0] sh;
    sh = cmd >> (8 * (FRAME_BYTES - 1 - int'(k)));
    return sh[7:0];
  endfunction

  assign pps_rise = pps & ~pps_q;
  assign tx_hs    = tx_valid_q & spi_tx_tready;
  assign tx_nxt   = tx_cnt + 3'd1;
  assign rx_take  = spi_rx_tvalid && (state == XFER) && (rx_cnt != FB);
  assign sample   = 16'(rx_frame[FRAME_W-1 -: ADC_BITS]);

  // Valids are masked by reset so they drop in the reset cycle itself.
  assign spi_tx_tvalid = tx_valid_q & ~rst;
  assign m_axis_tvalid = out_valid_q & ~rst;
  assign spi_rx_tready = ~rst;
  assign stat_busy     = (state != IDLE);
  assign stat_scan_cnt = scan_cnt;

  // Next higher enabled channel above the current pointer.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    nxt_found = 1'b0;
    nxt_ch    = ptr;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(ptr))) begin
        nxt_found = 1'b1;
        nxt_ch    = CH_W'(i);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every read
  // below sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: rx_frame is a plain shift register, not a memory, so it is reset too.
      state         <= IDLE;
      pps_q         <= 1'b0;
      mask_q        <= '0;
      ptr           <= '0;
      settle_cnt    <= '0;
      tx_cnt        <= '0;
      rx_cnt        <= '0;
      rx_frame      <= '0;
      tx_valid_q    <= 1'b0;
      spi_tx_tdata  <= '0;
      mux_sel       <= '0;
      mux_en        <= 1'b0;
      out_valid_q   <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      stat_overflow <= 1'b0;
      scan_cnt      <= '0;
    end else begin
      pps_q <= pps;

      if (out_valid_q && m_axis_tready) out_valid_q <= 1'b0;
      if (stat_clr_overflow) stat_overflow <= 1'b0;

      if (rx_take) begin
        rx_frame <= {rx_frame[FRAME_W-9:0], spi_rx_tdata};
        rx_cnt   <= rx_cnt + 3'd1;
      end

      case (state)
        IDLE: begin
          if (ctrl_enable && (|ctrl_ch_mask) && (!ctrl_pps_sync || pps_rise)) begin
            mask_q <= ctrl_ch_mask;
            ptr    <= lowest_set(ctrl_ch_mask);
            state  <= SELECT;
          end
        end

        SELECT: begin
          mux_sel    <= ptr;
          mux_en     <= 1'b1;
          settle_cnt <= ctrl_settle;
          tx_cnt     <= '0;
          rx_cnt     <= '0;
          state      <= (ctrl_settle == '0) ? XFER : SETTLE;
        end

        SETTLE: begin
          settle_cnt <= settle_cnt - SETTLE_W'(1);
          if (settle_cnt == SETTLE_W'(1)) state <= XFER;
        end

        XFER: begin
          if (tx_hs) begin
            tx_cnt <= tx_nxt;
            if (tx_nxt < FB) spi_tx_tdata <= cmd_byte(ctrl_cmd, tx_nxt);
            else             tx_valid_q   <= 1'b0;
          end else if (!tx_valid_q && (tx_cnt != FB)) begin
            tx_valid_q   <= 1'b1;
            spi_tx_tdata <= cmd_byte(ctrl_cmd, tx_cnt);
          end
          if ((tx_cnt == FB) && (rx_cnt == FB)) state <= STORE;
        end

        STORE: begin
          // A full, stalled output register keeps its beat; the new sample is lost.
          if (out_valid_q && !m_axis_tready) begin
            stat_overflow <= 1'b1;
          end else begin
            out_valid_q  <= 1'b1;
            m_axis_tdata <= {scan_cnt[7:0], 4'(ptr), 4'b0000, sample};
            m_axis_tlast <= ~nxt_found;
          end
          if (!nxt_found) scan_cnt <= scan_cnt + 16'd1;

          if (!ctrl_enable) begin
            state  <= IDLE;
            mux_en <= 1'b0;
          end else if (nxt_found) begin
            ptr   <= nxt_ch;
            state <= SELECT;
          end else if (ctrl_pps_sync || (ctrl_ch_mask == '0)) begin
            state  <= IDLE;
            mux_en <= 1'b0;
          end else begin
            mask_q <= ctrl_ch_mask;
            ptr    <= lowest_set(ctrl_ch_mask);
            state  <= SELECT;
          end
        end

        default: begin
          state  <= IDLE;
          mux_en <= 1'b0;
        end
      endcase
    end
  end

endmodule
